onchip_mem_byte_loader: RTL and testbench
=========================================

# onchip_mem_byte_loader

Upstream loader for the 32-bit single-port on-chip RAM. It accepts a byte stream with a valid/ready handshake and packs the bytes little-endian into 32-bit words. Each word is written into a ring region of the RAM through the RAM's Avalon-MM slave signals, with partial final words masked by byteenable. An optional readback check re-reads every written word and flags mismatches. It sits between the sensor/UART byte source and the RAM, so buffers are filled without NIOS involvement.

## Interface
Parameters:
- BASE_WORD, 0, first word address of the ring region
- DEPTH_WORDS, 40000, ring length in words; BASE_WORD+DEPTH_WORDS ≤ 65536
- VERIFY, 1, 1 = read back and compare each written word; 0 = no readback

Ports:
- clk  in  1  single clock for all logic and the RAM
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; clears write index, arms loader (ignored unless idle)
- in_data  in  8  stream byte
- in_valid  in  1  byte present
- in_last  in  1  qualifies in_data as the final byte of the transfer
- in_ready  out  1  loader accepts byte this cycle
- mem_address  out  16  RAM word address
- mem_byteenable  out  4  RAM byte lanes
- mem_chipselect  out  1  RAM select
- mem_write  out  1  RAM write strobe
- mem_writedata  out  32  RAM write data
- mem_clken  out  1  RAM clock enable, constant 1 out of reset
- mem_readdata  in  32  RAM read data, valid 1 cycle after a read address
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse after the last word is written/verified
- word_count  out  16  next ring write index (0..DEPTH_WORDS-1)
- overflow  out  1  sticky: ring wrapped since start
- verify_err  out  1  sticky: readback mismatch since start

## Operation
- States: IDLE, COLLECT, WRITE, RD, CHK.
- IDLE: in_ready=0.
  - start → clear word_count, overflow, verify_err and byte lane counter; go to COLLECT.
- COLLECT: in_ready=1.
  - A byte is accepted when in_valid&in_ready; it goes to lane k (bits 8k+7:8k), then k increments.
  - On the 4th byte, or on a byte with in_last, go to WRITE.
- WRITE: one cycle with mem_chipselect=1, mem_write=1, mem_address=BASE_WORD+word_count.
  - mem_byteenable = 4'b1111 for a full word.
  - For a partial word with n bytes (n=1,2,3): 0001, 0011, 0111.
  - Unfilled lanes of writedata are 0.
  - If VERIFY=1 go to RD, else advance.
- RD: mem_chipselect=1, mem_write=0, same address.
- CHK: compare mem_readdata with the written data on enabled lanes only; a mismatch sets verify_err. Then advance.
- Advance:
  - word_count+1; if it reaches DEPTH_WORDS, wrap to 0 and set overflow. The next write overwrites the oldest word.
  - Lane counter clears.
  - If the word held the last byte: pulse done, go to IDLE. Otherwise go to COLLECT.
- start outside IDLE is ignored.
- in_last on the 4th byte produces a full word and done; there is no extra empty write.
- mem_chipselect=0 and mem_write=0 in every state except WRITE and RD.

## Timing
- Reset values:
  - in_ready, mem_chipselect, mem_write, busy, done, overflow, verify_err = 0
  - mem_address, mem_byteenable, mem_writedata, word_count = 0
  - mem_clken = 1
  - state = IDLE
- All outputs are registered.
- busy=1 from the cycle after start through the cycle done is asserted.
- Latency:
  - WRITE is asserted the cycle after the word-completing byte is accepted.
  - Per word: 4 accept cycles + 1 (VERIFY=0) or + 3 (VERIFY=1).
  - done is asserted the cycle after the final advance decision.
- The RAM has no waitrequest; every write/read strobe completes in its one cycle.
- Asynchronous reset mid-transfer aborts immediately. Bytes in the packer are discarded and RAM contents are unchanged.

## Structure
- Shared package, loader_pkg:
  - state enum
  - byteenable-from-count function (n→mask)
  - lane-masked compare function
- Sub-module byte_packer:
  - shift/lane register with lane counter, clear and complete flags
  - FSM and address counter stay in the top level
- The RAM is instantiated by the system, not by this block; the bench instantiates a behavioural RAM with 1-cycle read latency.

## Test plan
- VERIFY=1; start, then bytes 0x11,0x22,0x33,0x44 with last on 0x44 → one write at address BASE_WORD, data 0x44332211, be 1111; readback passes; done pulse; word_count=1; verify_err=0.
- Bytes 0xAA,0xBB with last on 0xBB → write data 0x0000BBAA, be 0011; RAM lanes 2–3 keep prior contents.
- DEPTH_WORDS=4; 20 bytes streamed with in_valid held high → writes to BASE_WORD+0..3, then +0; overflow=1, word_count=1.
- Bench RAM corrupts bit 5 of lane 1 on read → verify_err=1 and stays set until the next start.
- reset_n low during the 3rd byte of a word → all outputs return to reset values within the same cycle; no RAM write occurs.
- in_valid toggled randomly, start pulsed while busy → byte order and addresses unchanged; start is ignored.

Source files
------------

// File: rtl/onchip_mem_byte_loader_pkg.sv
// Shared types and helpers for the on-chip RAM byte loader: FSM state encoding,
// byte-count to byteenable mapping and lane-masked word comparison.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE,
        ST_RD,
        ST_CHK
    } state_t;

    function automatic logic [3:0] be_from_count(input logic [2:0] n);
        case (n)
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0011;
            3'd3:    return 4'b0111;
            3'd4:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic lanes_match(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [3:0]  be);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i] && (a[8*i +: 8] != b[8*i +: 8]))
                ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/onchip_mem_byte_loader_byte_packer.sv
// Little-endian byte packer: places each pushed byte in the next lane of a
// 32-bit word and flags when the word is complete (4 bytes or a last byte).
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  data,
    input  logic        last,
    output logic [31:0] word_next,
    output logic [2:0]  count_next,
    output logic        complete,
    output logic        last_seen
);

    logic [31:0] word_q;
    logic [2:0]  count_q;
    logic        last_q;
    logic        last_next;

    always_comb begin
        word_next  = word_q;
        count_next = count_q;
        last_next  = last_q;
        complete   = 1'b0;
        if (clear) begin
            word_next  = '0;
            count_next = '0;
            last_next  = 1'b0;
        end else if (push) begin
            word_next[{count_q[1:0], 3'b000} +: 8] = data;
            count_next = count_q + 3'd1;
            last_next  = last_q | last;
            complete   = (count_q == 3'd3) || last;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_q  <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
        end else begin
            word_q  <= word_next;
            count_q <= count_next;
            last_q  <= last_next;
        end
    end

    assign last_seen = last_q;

endmodule

// File: rtl/onchip_mem_byte_loader.sv
// Streams bytes into a ring region of the 32-bit on-chip RAM over its Avalon-MM
// slave port, with optional per-word readback verification.
module onchip_mem_byte_loader
    import loader_pkg::*;
#(
    parameter int unsigned BASE_WORD   = 0,
    parameter int unsigned DEPTH_WORDS = 40000,
    parameter int unsigned VERIFY      = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [15:0] mem_address,
    output logic [3:0]  mem_byteenable,
    output logic        mem_chipselect,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic        mem_clken,
    input  logic [31:0] mem_readdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] word_count,
    output logic        overflow,
    output logic        verify_err
);

    localparam logic [15:0] BASE_L  = 16'(BASE_WORD);
    localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

    state_t      state, state_next;
    logic [15:0] wc_next;
    logic [16:0] wc_plus;
    logic        ovf_next, verr_next, busy_next, done_next, ready_next;
    logic        cs_next, we_next, advance;
    logic [15:0] addr_next;
    logic [3:0]  be_next;
    logic [31:0] wd_next;

    logic        pk_clear, pk_push, pk_complete, pk_last_seen;
    logic [31:0] pk_word_next;
    logic [2:0]  pk_count_next;

    byte_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (pk_clear),
        .push       (pk_push),
        .data       (in_data),
        .last       (in_last),
        .word_next  (pk_word_next),
        .count_next (pk_count_next),
        .complete   (pk_complete),
        .last_seen  (pk_last_seen)
    );

    always_comb begin
        state_next = state;
        wc_next    = word_count;
        wc_plus    = {1'b0, word_count} + 17'd1;
        ovf_next   = overflow;
        verr_next  = verify_err;
        addr_next  = mem_address;
        be_next    = mem_byteenable;
        wd_next    = mem_writedata;
        busy_next  = 1'b1;
        done_next  = 1'b0;
        pk_clear   = 1'b0;
        pk_push    = 1'b0;
        advance    = 1'b0;

        case (state)
            ST_IDLE: begin
                busy_next = 1'b0;
                if (start) begin
                    state_next = ST_COLLECT;
                    wc_next    = '0;
                    ovf_next   = 1'b0;
                    verr_next  = 1'b0;
                    pk_clear   = 1'b1;
                    busy_next  = 1'b1;
                end
            end
            ST_COLLECT: begin
                pk_push = in_valid & in_ready;
                // Write beat is registered from the packer's next-word view so it
                // lands in the cycle right after the completing byte.
                if (pk_complete) begin
                    state_next = ST_WRITE;
                    addr_next  = BASE_L + word_count;
                    be_next    = be_from_count(pk_count_next);
                    wd_next    = pk_word_next;
                end
            end
            ST_WRITE: begin
                if (VERIFY != 0)
                    state_next = ST_RD;
                else
                    advance = 1'b1;
            end
            ST_RD: state_next = ST_CHK;
            ST_CHK: begin
                if (!lanes_match(mem_readdata, mem_writedata, mem_byteenable))
                    verr_next = 1'b1;
                advance = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase

        if (advance) begin
            pk_clear = 1'b1;
            if (wc_plus == DEPTH_L) begin
                wc_next  = '0;
                ovf_next = 1'b1;
            end else begin
                wc_next = wc_plus[15:0];
            end
            if (pk_last_seen) begin
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end else begin
                state_next = ST_COLLECT;
            end
        end

        ready_next = (state_next == ST_COLLECT);
        cs_next    = (state_next == ST_WRITE) || (state_next == ST_RD);
        we_next    = (state_next == ST_WRITE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            word_count     <= '0;
            overflow       <= 1'b0;
            verify_err     <= 1'b0;
            in_ready       <= 1'b0;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_byteenable <= '0;
            mem_writedata  <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mem_clken      <= 1'b1;
        end else begin
            state          <= state_next;
            word_count     <= wc_next;
            overflow       <= ovf_next;
            verify_err     <= verr_next;
            in_ready       <= ready_next;
            mem_chipselect <= cs_next;
            mem_write      <= we_next;
            mem_address    <= addr_next;
            mem_byteenable <= be_next;
            mem_writedata  <= wd_next;
            busy           <= busy_next;
            done           <= done_next;
            mem_clken      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_onchip_mem_byte_loader.sv
// Directed bench for onchip_mem_byte_loader with a behavioural 1-cycle-latency RAM
// that can corrupt bit 5 of lane 1 on readback.
module tb_onchip_mem_byte_loader;

    localparam int unsigned BASE  = 16;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [15:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = '0;
    logic        busy, done, overflow, verify_err;
    logic [15:0] word_count;

    logic        corrupt = 1'b0;
    logic [31:0] ram [0:255];
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [31:0] log_be[$];

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    onchip_mem_byte_loader #(
        .BASE_WORD   (BASE),
        .DEPTH_WORDS (DEPTH),
        .VERIFY      (1)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .busy           (busy),
        .done           (done),
        .word_count     (word_count),
        .overflow       (overflow),
        .verify_err     (verify_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_chipselect && mem_write) begin
            for (int i = 0; i < 4; i++)
                if (mem_byteenable[i])
                    ram[mem_address[7:0]][8*i +: 8] <= mem_writedata[8*i +: 8];
            log_addr.push_back({16'h0, mem_address});
            log_data.push_back(mem_writedata);
            log_be.push_back({28'h0, mem_byteenable});
        end else if (mem_chipselect) begin
            mem_readdata <= ram[mem_address[7:0]] ^ (corrupt ? 32'h0000_2000 : 32'h0);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ctrl"}, {24'h0, in_ready, mem_chipselect, mem_write, busy,
                               done, overflow, verify_err, mem_clken}, 32'h0000_0001);
        check({tag, "_addr"}, {16'h0, mem_address}, 32'h0);
        check({tag, "_be"}, {28'h0, mem_byteenable}, 32'h0);
        check({tag, "_wdata"}, mem_writedata, 32'h0);
        check({tag, "_wc"}, {16'h0, word_count}, 32'h0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input logic last);
        int unsigned n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        in_last  = last;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("send_timeout", 32'h0, 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        int unsigned n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 50);
        if (!done) check("done_timeout", 32'h0, 32'h1);
    endtask

    task automatic idle_gap(input int unsigned n, input logic poke);
        in_valid = 1'b0;
        for (int unsigned i = 0; i < n; i++) begin
            start = poke && (i == 0);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    logic [31:0] ring_data [0:4] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09,
                                     32'h100F0E0D, 32'h14131211};
    logic [31:0] ring_addr [0:4] = '{32'd16, 32'd17, 32'd18, 32'd19, 32'd16};
    int unsigned n_before;

    initial begin
        repeat (3) @(negedge clk);
        check_reset("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Full word with last on the 4th byte
        pulse_start();
        check("start_busy", {31'h0, busy}, 32'h1);
        check("start_ready", {31'h0, in_ready}, 32'h1);
        log_addr.delete(); log_data.delete(); log_be.delete();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        check("w1_write", {30'h0, mem_chipselect, mem_write}, 32'h3);
        check("w1_addr", {16'h0, mem_address}, 32'd16);
        check("w1_wdata", mem_writedata, 32'h44332211);
        check("w1_be", {28'h0, mem_byteenable}, 32'hF);
        @(negedge clk);
        check("w1_rd", {30'h0, mem_chipselect, mem_write}, 32'h2);
        check("w1_rd_addr", {16'h0, mem_address}, 32'd16);
        @(negedge clk);
        check("w1_chk_idle_bus", {30'h0, mem_chipselect, mem_write}, 32'h0);
        @(negedge clk);
        check("w1_done", {31'h0, done}, 32'h1);
        check("w1_busy_at_done", {31'h0, busy}, 32'h1);
        check("w1_wc", {16'h0, word_count}, 32'd1);
        check("w1_verr", {31'h0, verify_err}, 32'h0);
        check("w1_nwrites", log_addr.size(), 32'd1);
        @(negedge clk);
        check("w1_done_pulse", {30'h0, done, busy}, 32'h0);

        // Partial word: two bytes, lanes 2-3 must keep prior RAM contents
        pulse_start();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b1);
        check("p2_wdata", mem_writedata, 32'h0000BBAA);
        check("p2_be", {28'h0, mem_byteenable}, 32'h3);
        check("p2_addr", {16'h0, mem_address}, 32'd16);
        wait_done();
        check("p2_ram", ram[16], 32'h4433BBAA);
        check("p2_verr", {31'h0, verify_err}, 32'h0);

        // Ring wrap: 20 bytes into a 4-word ring
        pulse_start();
        log_addr.delete(); log_data.delete(); log_be.delete();
        for (int i = 1; i <= 20; i++)
            send_byte(8'(i), i == 20);
        wait_done();
        check("ring_nwrites", log_addr.size(), 32'd5);
        for (int i = 0; i < 5 && i < log_addr.size(); i++) begin
            check($sformatf("ring_addr%0d", i), log_addr[i], ring_addr[i]);
            check($sformatf("ring_data%0d", i), log_data[i], ring_data[i]);
        end
        check("ring_ovf", {31'h0, overflow}, 32'h1);
        check("ring_wc", {16'h0, word_count}, 32'd1);

        // Readback corruption on lane 1: masked for a 1-byte word, flagged for a full word
        corrupt = 1'b1;
        pulse_start();
        send_byte(8'h5A, 1'b1);
        wait_done();
        check("vfy_masked", {31'h0, verify_err}, 32'h0);
        pulse_start();
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        send_byte(8'hBE, 1'b0);
        send_byte(8'hEF, 1'b1);
        wait_done();
        check("vfy_err", {31'h0, verify_err}, 32'h1);
        corrupt = 1'b0;
        repeat (5) @(negedge clk);
        check("vfy_sticky", {31'h0, verify_err}, 32'h1);
        pulse_start();
        check("vfy_cleared", {31'h0, verify_err}, 32'h0);

        // Asynchronous reset while the 3rd byte is offered
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        n_before = log_addr.size();
        in_data  = 8'h03;
        in_valid = 1'b1;
        #2 reset_n = 1'b0;
        #1 check_reset("midrst");
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_nowrite", log_addr.size(), n_before);
        check("midrst_idle", {30'h0, in_ready, busy}, 32'h0);

        // Gappy stream with start pulses while busy
        pulse_start();
        log_addr.delete(); log_data.delete(); log_be.delete();
        for (int i = 1; i <= 8; i++) begin
            idle_gap($urandom_range(0, 3), 1'($urandom_range(0, 1)));
            send_byte(8'h80 + 8'(i), i == 8);
            if (i == 4) pulse_start();
        end
        wait_done();
        check("gap_nwrites", log_addr.size(), 32'd2);
        if (log_addr.size() >= 2) begin
            check("gap_addr0", log_addr[0], 32'd16);
            check("gap_data0", log_data[0], 32'h84838281);
            check("gap_addr1", log_addr[1], 32'd17);
            check("gap_data1", log_data[1], 32'h88878685);
        end
        check("gap_wc", {16'h0, word_count}, 32'd2);
        check("gap_verr", {31'h0, verify_err}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
